// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair: select encoding,
// sequence states and frame counter width.
package tdm_pkg;
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic {EXP_A, EXP_B} seq_state_t;
endpackage

// File: rtl/tdm_demux2_if.sv
// Shared input stream plus the two channel output handshakes of tdm_demux2.
interface tdm_demux2_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
    );
    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/tdm_demux2_out_slot.sv
// One-entry registered output slot; a write in the same cycle as a drain
// replaces the payload and keeps the slot full.
module out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             can_accept,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);
    assign can_accept = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (wr_en) begin
                valid <= 1'b1;
                data  <= wr_data;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer with A-then-B frame order checking,
// a sticky misorder flag and a wrapping frame counter.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STRICT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    tdm_demux2_if.slave            bus,
    output logic                   seq_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    logic a_can, b_can, accept, wr_a, wr_b;
    logic err_d;
    logic [FRAME_CNT_W-1:0] cnt_d;
    seq_state_t state_q, state_d;

    assign bus.in_ready = (bus.in_sel == CH_A) ? a_can : b_can;
    assign accept = bus.in_valid && bus.in_ready;
    assign wr_a   = accept && (bus.in_sel == CH_A);
    assign wr_b   = accept && (bus.in_sel == CH_B);

    out_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk(clk), .reset(reset), .wr_en(wr_a), .wr_data(bus.in_data),
        .can_accept(a_can), .valid(bus.a_valid), .ready(bus.a_ready), .data(bus.a_data)
    );

    out_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk(clk), .reset(reset), .wr_en(wr_b), .wr_data(bus.in_data),
        .can_accept(b_can), .valid(bus.b_valid), .ready(bus.b_ready), .data(bus.b_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EXP_A;
            seq_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            seq_err   <= err_d;
            frame_cnt <= cnt_d;
        end
    end

    // A repeated A while expecting B restarts the frame rather than closing it.
    always_comb begin
        state_d = state_q;
        err_d   = seq_err;
        cnt_d   = frame_cnt;
        if (accept) begin
            case (state_q)
                EXP_A: begin
                    if (bus.in_sel == CH_A) state_d = EXP_B;
                    else if (STRICT != 0)   err_d = 1'b1;
                end
                EXP_B: begin
                    if (bus.in_sel == CH_B) begin
                        state_d = EXP_A;
                        cnt_d   = frame_cnt + 1'b1;
                    end else if (STRICT != 0) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = EXP_A;
            endcase
        end
    end
endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2: a STRICT=1 and a STRICT=0 instance share
// the same stimulus.
module tb_tdm_demux2;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    tdm_demux2_if #(.WIDTH(8)) bus1();
    tdm_demux2_if #(.WIDTH(8)) bus0();
    logic       seq_err1, seq_err0;
    logic [7:0] frame_cnt1, frame_cnt0;

    assign bus0.in_valid = bus1.in_valid;
    assign bus0.in_sel   = bus1.in_sel;
    assign bus0.in_data  = bus1.in_data;
    assign bus0.a_ready  = bus1.a_ready;
    assign bus0.b_ready  = bus1.b_ready;

    tdm_demux2 #(.WIDTH(8), .STRICT(1)) dut_strict (
        .clk(clk), .reset(reset), .bus(bus1), .seq_err(seq_err1), .frame_cnt(frame_cnt1)
    );
    tdm_demux2 #(.WIDTH(8), .STRICT(0)) dut_loose (
        .clk(clk), .reset(reset), .bus(bus0), .seq_err(seq_err0), .frame_cnt(frame_cnt0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic sel, input logic [7:0] d);
        int n;
        n = 0;
        bus1.in_valid = 1'b1;
        bus1.in_sel   = sel;
        bus1.in_data  = d;
        @(negedge clk);
        while (!bus1.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_a_valid"}, bus1.a_valid, 0);
        chk({tag, "_b_valid"}, bus1.b_valid, 0);
        chk({tag, "_a_data"}, bus1.a_data, 0);
        chk({tag, "_b_data"}, bus1.b_data, 0);
        chk({tag, "_seq_err"}, seq_err1, 0);
        chk({tag, "_frame_cnt"}, frame_cnt1, 0);
    endtask

    logic       sels [4] = '{CH_A, CH_B, CH_A, CH_B};
    logic [7:0] dats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        bus1.in_valid = 1'b0;
        bus1.in_sel   = CH_A;
        bus1.in_data  = 8'h00;
        bus1.a_ready  = 1'b1;
        bus1.b_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("rst");
        @(negedge clk);
        chk("rst_in_ready", bus1.in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back alternating beats, no bubbles.
        for (int i = 0; i < 4; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_sel   = sels[i];
            bus1.in_data  = dats[i];
            @(negedge clk);
            chk($sformatf("stream_in_ready%0d", i), bus1.in_ready, 1);
            @(posedge clk); #1;
            if (sels[i] == CH_A) begin
                chk($sformatf("stream_a_valid%0d", i), bus1.a_valid, 1);
                chk($sformatf("stream_a_data%0d", i), bus1.a_data, 32'(dats[i]));
            end else begin
                chk($sformatf("stream_b_valid%0d", i), bus1.b_valid, 1);
                chk($sformatf("stream_b_data%0d", i), bus1.b_data, 32'(dats[i]));
            end
        end
        bus1.in_valid = 1'b0;
        chk("stream_frame_cnt", frame_cnt1, 2);
        chk("stream_seq_err", seq_err1, 0);

        // Backpressure on A; B keeps flowing.
        bus1.a_ready = 1'b0;
        @(posedge clk); #1;
        send(CH_A, 8'h55);
        chk("bp_a_data55", bus1.a_data, 8'h55);
        bus1.in_valid = 1'b1;
        bus1.in_sel   = CH_A;
        bus1.in_data  = 8'h66;
        @(negedge clk);
        chk("bp_stall_in_ready", bus1.in_ready, 0);
        @(posedge clk); #1;
        chk("bp_a_held", bus1.a_data, 8'h55);
        bus1.in_sel  = CH_B;
        bus1.in_data = 8'h77;
        @(negedge clk);
        chk("bp_b_in_ready", bus1.in_ready, 1);
        @(posedge clk); #1;
        chk("bp_b_valid", bus1.b_valid, 1);
        chk("bp_b_data", bus1.b_data, 8'h77);
        chk("bp_a_still55", bus1.a_data, 8'h55);
        chk("bp_frame_cnt", frame_cnt1, 3);
        bus1.in_sel  = CH_A;
        bus1.in_data = 8'h66;
        @(negedge clk);
        chk("bp_a_stall2", bus1.in_ready, 0);
        bus1.a_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus1.in_ready, 1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk("bp_a_valid66", bus1.a_valid, 1);
        chk("bp_a_data66", bus1.a_data, 8'h66);
        @(posedge clk); #1;
        chk("bp_a_drained", bus1.a_valid, 0);
        chk("bp_a_data_hold", bus1.a_data, 8'h66);

        // Misorder from EXP_A.
        pulse_reset();
        send(CH_B, 8'h01);
        chk("ord_b_valid", bus1.b_valid, 1);
        chk("ord_b_data", bus1.b_data, 8'h01);
        chk("ord_seq_err", seq_err1, 1);
        chk("ord_frame_cnt", frame_cnt1, 0);
        chk("ord_loose_err", seq_err0, 0);
        send(CH_A, 8'h02);
        send(CH_B, 8'h03);
        chk("ord_frame_cnt1", frame_cnt1, 1);
        chk("ord_seq_err_sticky", seq_err1, 1);
        chk("ord_loose_frame_cnt", frame_cnt0, 1);

        // Counter wrap.
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            send(CH_A, 8'(i));
            send(CH_B, 8'(~i));
        end
        chk("wrap_zero", frame_cnt1, 0);
        chk("wrap_seq_err", seq_err1, 0);
        send(CH_A, 8'h5A);
        send(CH_B, 8'hA5);
        chk("wrap_one", frame_cnt1, 1);

        // Reset mid-stream with A full, FSM in EXP_B, seq_err set.
        pulse_reset();
        bus1.a_ready = 1'b0;
        send(CH_B, 8'h0F);
        send(CH_A, 8'hAA);
        chk("mid_a_valid", bus1.a_valid, 1);
        chk("mid_a_data", bus1.a_data, 8'hAA);
        chk("mid_seq_err", seq_err1, 1);
        bus1.in_valid = 1'b1;
        bus1.in_sel   = CH_B;
        bus1.in_data  = 8'h99;
        pulse_reset();
        bus1.in_valid = 1'b0;
        check_reset_state("mid");
        @(negedge clk);
        chk("mid_in_ready", bus1.in_ready, 1);
        bus1.a_ready = 1'b1;
        @(posedge clk); #1;
        send(CH_A, 8'hBB);
        chk("mid_a_bb", bus1.a_data, 8'hBB);
        chk("mid_fsm_exp_a", seq_err1, 0);
        send(CH_B, 8'hCC);
        chk("mid_frame_cnt", frame_cnt1, 1);

        // STRICT=0 versus STRICT=1 on B, B, A.
        pulse_reset();
        send(CH_B, 8'hB1);
        chk("loose_b1", bus0.b_data, 8'hB1);
        send(CH_B, 8'hB2);
        chk("loose_b2", bus0.b_data, 8'hB2);
        send(CH_A, 8'hA3);
        chk("loose_a3", bus0.a_data, 8'hA3);
        chk("loose_a3_valid", bus0.a_valid, 1);
        chk("loose_seq_err", seq_err0, 0);
        chk("strict_seq_err", seq_err1, 1);
        chk("loose_frame_cnt", frame_cnt0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
